// File: rtl/axis_uart_tx.sv
// AXI-stream byte sink that serialises each accepted byte as an 8N1 UART frame and counts packets.
// Latency: start bit drives the line the cycle after acceptance; a frame is 10*DIV cycles long.
// Backpressure: o_tready is high only in IDLE, so the stream stalls for the whole frame.
module axis_uart_tx #(
    parameter int CLK_FREQ_HZ = 16000000,
    parameter int BAUD_RATE   = 57600
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        o_tready,
    output logic        o_uart_tx,
    output logic        o_busy,
    output logic [15:0] o_pkt_cnt
);

    // Cycles per serial bit; truncating division so the bit period is an exact cycle count.
    localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    // A baud divider below two cannot hold a bit for a whole period; refuse to build.
    if (DIV < 2) begin : g_div_check
        $fatal(1, "axis_uart_tx: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          state_q,   state_d;
    logic [CW-1:0]   baud_q,    baud_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      data_q,    data_d;
    logic            last_q,    last_d;
    logic            tready_q,  tready_d;
    logic            tx_q,      tx_d;
    logic [15:0]     pkt_cnt_q, pkt_cnt_d;

    logic            bit_end;

    assign bit_end = (baud_q == DIV_LAST);

    // Next-state logic: the line level is computed for the upcoming cycle so tx_q stays a clean flop.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        last_d    = last_q;
        tready_d  = tready_q;
        tx_d      = tx_q;
        pkt_cnt_d = pkt_cnt_q;

        case (state_q)
            S_IDLE: begin
                // Counter and index parked at zero; ready rises one edge after reset release.
                baud_d    = '0;
                bit_idx_d = '0;
                tready_d  = 1'b1;
                tx_d      = 1'b1;
                if (tready_q && i_tvalid) begin
                    state_d  = S_START;
                    data_d   = i_tdata;
                    last_d   = i_tlast;
                    tready_d = 1'b0;
                    tx_d     = 1'b0;
                end
            end

            S_START: begin
                tready_d = 1'b0;
                if (bit_end) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                    tx_d      = data_q[0];
                end else begin
                    baud_d = baud_q + CW'(1);
                    tx_d   = 1'b0;
                end
            end

            S_DATA: begin
                tready_d = 1'b0;
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = data_q[bit_idx_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                    tx_d   = data_q[bit_idx_q];
                end
            end

            S_STOP: begin
                tready_d = 1'b0;
                tx_d     = 1'b1;
                if (bit_end) begin
                    // Leaving STOP: the byte is fully on the wire, so a packet end counts now.
                    baud_d   = '0;
                    state_d  = S_IDLE;
                    tready_d = 1'b1;
                    if (last_q) begin
                        pkt_cnt_d = pkt_cnt_q + 16'd1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end

            default: begin
                state_d  = S_IDLE;
                baud_d   = '0;
                tready_d = 1'b0;
                tx_d     = 1'b1;
            end
        endcase
    end

    // State register; reset drops any partial frame and forces the line idle-high at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            tready_q  <= 1'b0;
            tx_q      <= 1'b1;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            last_q    <= last_d;
            tready_q  <= tready_d;
            tx_q      <= tx_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign o_tready  = tready_q;
    assign o_uart_tx = tx_q;
    assign o_busy    = (state_q != S_IDLE);
    assign o_pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_axis_uart_tx.sv
module tb_axis_uart_tx;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [7:0]  i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        o_tready;
    logic        o_uart_tx;
    logic        o_busy;
    logic [15:0] o_pkt_cnt;

    int checks = 0;
    int errors = 0;

    axis_uart_tx #(
        .CLK_FREQ_HZ(400),
        .BAUD_RATE  (100)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .o_tready (o_tready),
        .o_uart_tx(o_uart_tx),
        .o_busy   (o_busy),
        .o_pkt_cnt(o_pkt_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0]  data;
        logic        last;
        logic        toggle;
        logic [9:0]  frame;   // bit 0 = start bit, bit 9 = stop bit, line order
        logic [15:0] cnt;     // packet count expected after the stop bit
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!o_tready && n < 100) begin
            tick();
            n++;
        end
        chk({name, " ready_wait"}, 128'(o_tready), 128'd1);
    endtask

    // Sends one byte and captures the line for the 40 cycles following acceptance.
    task automatic send_frame(input string name, input logic [7:0] data, input logic last,
                              input logic toggle, input logic [9:0] frame, input logic [15:0] exp_cnt);
        logic [39:0] got;
        logic [39:0] exp;
        int busy_n = 0;
        int rdy_n  = 0;
        wait_ready(name);
        i_tdata  = data;
        i_tlast  = last;
        i_tvalid = 1'b1;
        tick();
        i_tvalid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            got[i] = o_uart_tx;
            exp[i] = frame[i / 4];
            busy_n += int'(o_busy);
            rdy_n  += int'(o_tready);
            if (toggle) begin
                i_tdata  = ~i_tdata ^ 8'(i);
                i_tvalid = i[0];
                i_tlast  = ~i_tlast;
            end
            tick();
        end
        i_tvalid = 1'b0;
        chk({name, " serial"}, 128'(got), 128'(exp));
        chk({name, " busy_cycles"}, 128'(busy_n), 128'd40);
        chk({name, " tready_while_busy"}, 128'(rdy_n), 128'd0);
        chk({name, " idle_after"}, 128'({o_busy, o_tready, o_uart_tx}), 128'(3'b011));
        chk({name, " pkt_cnt"}, 128'(o_pkt_cnt), 128'(exp_cnt));
    endtask

    initial begin
        logic [81:0] got_tx, exp_tx, got_rdy, exp_rdy;
        logic [9:0]  f00, fff;
        logic [15:0] cnt80, cnt81;
        int bad_tx, bad_rdy, bad_busy;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 10'b1_10100101_0, 16'd0};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 10'b1_00111100_0, 16'd0};
        vecs[2] = '{8'h55, 1'b1, 1'b0, 10'b1_01010101_0, 16'd1};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 10'b1_00000000_0, 16'd2};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 10'b1_11111111_0, 16'd2};
        vecs[5] = '{8'h81, 1'b1, 1'b0, 10'b1_10000001_0, 16'd3};

        // Reset state
        i_rst_n  = 1'b0;
        i_tdata  = 8'h00;
        i_tlast  = 1'b0;
        i_tvalid = 1'b0;
        #12;
        chk("reset tx", 128'(o_uart_tx), 128'd1);
        chk("reset tready", 128'(o_tready), 128'd0);
        chk("reset busy", 128'(o_busy), 128'd0);
        chk("reset pkt_cnt", 128'(o_pkt_cnt), 128'd0);
        #11;
        i_rst_n = 1'b1;
        tick();
        chk("tready after release", 128'(o_tready), 128'd1);

        // Stall: nothing offered for 100 cycles
        bad_tx = 0; bad_rdy = 0; bad_busy = 0;
        for (int i = 0; i < 100; i++) begin
            if (o_uart_tx !== 1'b1) bad_tx++;
            if (o_tready !== 1'b1) bad_rdy++;
            if (o_busy !== 1'b0) bad_busy++;
            tick();
        end
        chk("stall tx_not_high", 128'(bad_tx), 128'd0);
        chk("stall tready_not_high", 128'(bad_rdy), 128'd0);
        chk("stall busy_high", 128'(bad_busy), 128'd0);

        // Table-driven single frames
        for (int v = 0; v < 6; v++) begin
            send_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].last, vecs[v].toggle,
                       vecs[v].frame, vecs[v].cnt);
        end

        // Back-to-back with tvalid held high: 0x00 then 0xFF (tlast)
        f00 = 10'b1_00000000_0;
        fff = 10'b1_11111111_0;
        wait_ready("b2b");
        i_tdata  = 8'h00;
        i_tlast  = 1'b0;
        i_tvalid = 1'b1;
        tick();
        i_tdata = 8'hFF;
        i_tlast = 1'b1;
        cnt80 = '0; cnt81 = '0;
        for (int i = 0; i < 82; i++) begin
            got_tx[i]  = o_uart_tx;
            got_rdy[i] = o_tready;
            if (i < 40)       exp_tx[i] = f00[i / 4];
            else if (i == 40) exp_tx[i] = 1'b1;
            else if (i < 81)  exp_tx[i] = fff[(i - 41) / 4];
            else              exp_tx[i] = 1'b1;
            exp_rdy[i] = (i == 40 || i == 81);
            if (i == 41) i_tvalid = 1'b0;
            if (i == 80) cnt80 = o_pkt_cnt;
            if (i == 81) cnt81 = o_pkt_cnt;
            tick();
        end
        chk("b2b serial", 128'(got_tx), 128'(exp_tx));
        chk("b2b tready", 128'(got_rdy), 128'(exp_rdy));
        chk("b2b cnt before stop end", 128'(cnt80), 128'd3);
        chk("b2b cnt after stop end", 128'(cnt81), 128'd4);

        // Reset during DATA bit 3 of 0xC3 (bit 3 is 0)
        wait_ready("rst");
        i_tdata  = 8'hC3;
        i_tlast  = 1'b1;
        i_tvalid = 1'b1;
        tick();
        i_tvalid = 1'b0;
        repeat (17) tick();
        chk("mid busy", 128'(o_busy), 128'd1);
        chk("mid tx bit3", 128'(o_uart_tx), 128'd0);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("async rst tx", 128'(o_uart_tx), 128'd1);
        chk("async rst busy", 128'(o_busy), 128'd0);
        chk("async rst tready", 128'(o_tready), 128'd0);
        chk("async rst pkt_cnt", 128'(o_pkt_cnt), 128'd0);
        tick();
        tick();
        chk("held rst tx", 128'(o_uart_tx), 128'd1);
        #2;
        i_rst_n = 1'b1;
        tick();
        chk("rst release tready", 128'(o_tready), 128'd1);
        send_frame("after_rst", 8'h55, 1'b0, 1'b0, 10'b1_01010101_0, 16'd0);

        // Counter wrap
        force dut.pkt_cnt_q = 16'hFFFF;
        tick();
        release dut.pkt_cnt_q;
        tick();
        chk("wrap preload", 128'(o_pkt_cnt), 128'hFFFF);
        send_frame("wrap", 8'h0F, 1'b1, 1'b0, 10'b1_00001111_0, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axis_uart_tx.md
AXIS_UART_TX -- requirements
Module: axis_uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 16000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 57600, serial bit rate in bit/s.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_tdata  input  8  AXI-stream byte to transmit.
REQ-006 SHALL have port i_tlast  input  1  marks last byte of a packet.
REQ-007 SHALL have port i_tvalid  input  1  AXI-stream valid.
REQ-008 SHALL have port o_tready  output  1  AXI-stream ready.
REQ-009 SHALL have port o_uart_tx  output  1  serial line, 8N1, idle high.
REQ-010 SHALL have port o_busy  output  1  high while a frame is in progress.
REQ-011 SHALL have port o_pkt_cnt  output  16  count of completed packets, i.e. tlast bytes fully sent.

Function
REQ-012 SHALL compute DIV = CLK_FREQ_HZ / BAUD_RATE, truncating integer division; every bit period is exactly DIV cycles; DIV >= 2 is required, elaboration SHALL fail otherwise.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP; reset state IDLE.
REQ-014 SHALL drive o_tready high only in IDLE, registered.
REQ-015 SHALL accept a byte on a rising edge where i_tvalid and o_tready are both high.
REQ-016 On acceptance SHALL latch i_tdata and i_tlast, deassert o_tready, and enter START on that same edge.
REQ-017 SHALL ignore i_tdata, i_tlast and i_tvalid outside IDLE; the bench may change them freely while busy.
REQ-018 START: o_uart_tx low for DIV cycles, starting the cycle after acceptance; then DATA.
REQ-019 DATA: 8 bits, LSB first, each held DIV cycles, tracked by a 3-bit bit index; after bit 7, enter STOP.
REQ-020 STOP: o_uart_tx high for DIV cycles; then IDLE, with o_tready high in that first IDLE cycle.
REQ-021 Frame length SHALL be 10*DIV cycles; minimum acceptance-to-acceptance spacing SHALL be 10*DIV+1 cycles.
REQ-022 o_uart_tx SHALL be a registered output, glitch-free, and high in IDLE.
REQ-023 o_busy SHALL be high in START, DATA and STOP, and low in IDLE.
REQ-024 The baud counter SHALL count 0..DIV-1, reload to 0 on each bit boundary, and be held at 0 in IDLE.
REQ-025 o_pkt_cnt SHALL increment by 1 on the edge leaving STOP when the latched tlast is 1; it SHALL wrap 0xFFFF -> 0x0000; bytes with tlast=0 SHALL not change it.
REQ-026 i_tvalid held high continuously SHALL yield back-to-back frames, each separated by exactly one idle-high cycle.

Reset
REQ-027 While i_rst_n is low: state IDLE, o_uart_tx=1, o_tready=0, o_busy=0, o_pkt_cnt=0, baud counter=0, bit index=0, latched data=0.
REQ-028 Assertion mid-frame SHALL take effect immediately (asynchronously): o_uart_tx returns high, and the partial frame is discarded and not counted.
REQ-029 o_tready SHALL go high on the first rising edge after i_rst_n deasserts.

Verification
REQ-030 Single byte: CLK_FREQ_HZ=400, BAUD_RATE=100 (DIV=4); send 0xA5 with tlast=0 -> o_uart_tx=0,1,0,1,0,0,1,0,1,1, each held 4 cycles; o_busy high 40 cycles; o_pkt_cnt stays 0.
REQ-031 Back-to-back: tvalid held high with 0x00 then 0xFF (tlast=1 on 0xFF) -> frames 41 cycles apart; o_pkt_cnt=1 after the second stop bit.
REQ-032 Busy-time input changes: tdata toggled every cycle during a frame carrying 0x3C -> serial output is exactly 0x3C; o_tready stays 0 throughout.
REQ-033 Reset mid-frame: assert i_rst_n=0 during DATA bit 3 -> o_uart_tx=1 and o_busy=0 immediately; after release, the next byte 0x55 is sent intact; o_pkt_cnt=0.
REQ-034 Counter wrap: preload 65535 tlast bytes, or force o_pkt_cnt to 0xFFFF; one further tlast byte -> o_pkt_cnt=0x0000.
REQ-035 Stall: i_tvalid low for 100 cycles -> o_uart_tx=1, o_tready=1 and o_busy=0 for all 100 cycles.
